// File: rtl/mux4_rr_sel_pkg.sv
// mux4_rr_sel_pkg: shared types and constants for the mux4 round-robin
// select generator (FSM states, channel codes, one-hot helper).
package mux4_rr_sel_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/mux4_rr_sel_rr_pick4.sv
// rr_pick4: combinational round-robin picker over four requests.
// Ports: req[3:0], last[1:0] in; pick[1:0] (first requester after last), any out.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] idx;

    // Scan from farthest to nearest offset so the nearest requester
    // after 'last' is the one that survives; offset 4 is 'last' itself.
    always_comb begin
        pick = last;
        idx  = last;
        any  = |req;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sel.sv
// mux4_rr_sel: round-robin generator for the mux4 select with per-grant dwell.
// Ports: clk, reset (sync, active-low), enable, req[3:0], dwell in;
//        sel[1:0], valid, grant[3:0], switch_pulse out (all registered).
module mux4_rr_sel
    import mux4_rr_sel_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               valid,
    output logic [3:0]         grant,
    output logic               switch_pulse
);

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         last_q, last_d;
    logic [3:0]         grant_q, grant_d;
    logic               valid_q, valid_d;
    logic               pulse_q, pulse_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic [1:0]         pick;
    logic               any;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sel_q   <= CH_A;
            last_q  <= CH_D;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && any) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!enable)         state_d = ST_IDLE;
                else if (!req[sel_q]) state_d = any ? ST_HOLD : ST_IDLE;
                else                 state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d   = sel_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        valid_d = (state_d == ST_HOLD);
        unique case (state_q)
            ST_IDLE: begin
                grant_d = 4'b0000;
                if (enable && any) begin
                    sel_d   = pick;
                    last_d  = pick;
                    grant_d = onehot4(pick);
                    cnt_d   = dwell;
                    pulse_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!enable) begin
                    grant_d = 4'b0000;
                end else if (!req[sel_q]) begin
                    grant_d = 4'b0000;
                    if (any) begin
                        sel_d   = pick;
                        last_d  = pick;
                        grant_d = onehot4(pick);
                        cnt_d   = dwell;
                        pulse_d = 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (pick != sel_q) begin
                    sel_d   = pick;
                    last_d  = pick;
                    grant_d = onehot4(pick);
                    cnt_d   = dwell;
                    pulse_d = 1'b1;
                end else begin
                    // Sole requester: keep the grant, restart its dwell.
                    cnt_d = dwell;
                end
            end
            default: grant_d = 4'b0000;
        endcase
    end

    assign sel          = sel_q;
    assign valid        = valid_q;
    assign grant        = grant_q;
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// tb_mux4_rr_sel: directed + random bench against a behavioural
// round-robin model, with a mux4 data path checked on every valid cycle.
module tb_mux4_rr_sel;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] dwell = 4'd0;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] grant;
    logic       switch_pulse;

    int total = 0;
    int bad = 0;

    logic [7:0] dat [4];
    logic [7:0] mux_y;

    // Reference model state (integers, run-length view of a grant).
    bit m_valid;
    int m_sel;
    int m_last;
    int m_held;
    int m_len;
    bit m_pulse;

    mux4_rr_sel #(.DWELL_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req          (req),
        .dwell        (dwell),
        .sel          (sel),
        .valid        (valid),
        .grant        (grant),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            2'd0:    mux_y = dat[0];
            2'd1:    mux_y = dat[1];
            2'd2:    mux_y = dat[2];
            default: mux_y = dat[3];
        endcase
    end

    function automatic int rr(input logic [3:0] r, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (r[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    task automatic give(input int ch);
        m_valid = 1'b1;
        m_sel   = ch;
        m_last  = ch;
        m_held  = 1;
        m_len   = int'(dwell) + 1;
        m_pulse = 1'b1;
    endtask

    task automatic model_update();
        int p;
        p = rr(req, m_last);
        m_pulse = 1'b0;
        if (!reset) begin
            m_valid = 1'b0;
            m_sel   = 0;
            m_last  = 3;
            m_held  = 0;
            m_len   = 0;
        end else if (!m_valid) begin
            if (enable && p >= 0) give(p);
        end else if (!enable) begin
            m_valid = 1'b0;
        end else if (!req[m_sel]) begin
            if (p >= 0) give(p);
            else m_valid = 1'b0;
        end else if (m_held < m_len) begin
            m_held++;
        end else if (p != m_sel) begin
            give(p);
        end else begin
            m_held = 1;
            m_len  = int'(dwell) + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h",
                   tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] eg;
        @(posedge clk);
        model_update();
        #1;
        eg = m_valid ? (4'b0001 << m_sel) : 4'b0000;
        chk("sel",   8'(sel),          8'(m_sel));
        chk("valid", 8'(valid),        8'(m_valid));
        chk("grant", 8'(grant),        8'(eg));
        chk("pulse", 8'(switch_pulse), 8'(m_pulse));
        if (m_valid) chk("mux", mux_y, dat[m_sel]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_grant(input int ch, input int budget);
        int n;
        n = 0;
        while (!(m_valid && m_sel == ch && m_held == 1) && n < budget) begin
            step();
            n++;
        end
        total++;
        assert (n < budget) else begin
            bad++;
            $error("FAIL wait_grant ch=%0d observed=timeout expected=grant", ch);
        end
    endtask

    initial begin
        dat[0] = 8'hA1;
        dat[1] = 8'hB2;
        dat[2] = 8'hC3;
        dat[3] = 8'hD4;
        m_valid = 1'b0;
        m_sel   = 0;
        m_last  = 3;
        m_held  = 0;
        m_len   = 0;
        m_pulse = 1'b0;

        reset = 1'b0;
        steps(2);
        reset  = 1'b1;
        enable = 1'b1;
        req    = 4'b0000;
        steps(5);

        req   = 4'b0001;
        dwell = 4'd2;
        steps(10);

        req   = 4'b1111;
        dwell = 4'd0;
        steps(6);

        req   = 4'b0110;
        dwell = 4'd3;
        steps(12);
        wait_grant(1, 20);
        step();
        req = 4'b0100;
        steps(3);

        req   = 4'b1000;
        dwell = 4'd1;
        wait_grant(3, 10);
        step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        req    = 4'b1001;
        steps(4);

        req   = 4'b0100;
        dwell = 4'd2;
        wait_grant(2, 10);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        req   = 4'b0101;
        steps(6);

        for (int i = 0; i < 400; i++) begin
            req    = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 39) != 0);
            dwell  = 4'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
